// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - four-key debouncer with press pulse and auto-repeat
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] KEY,
  input  logic       REPEAT_EN,
  output logic [3:0] PRESS,
  output logic [3:0] HELD
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW      = $clog2(RPT_MAX + 1);

  // Counters compare against "last value before terminal" so they never exceed the parameter.
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [3:0] sync_a;
  logic [3:0] sync_b;

  // Two-flop synchronizer, stored inverted so 1 means pressed; reset value is released.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_a <= 4'b0000;
      sync_b <= 4'b0000;
    end else begin
      sync_a <= ~KEY;
      sync_b <= sync_a;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_key
    logic [DW-1:0] db_cnt;
    logic [RW-1:0] rpt_cnt;
    logic [RW-1:0] rpt_cnt_d;
    logic [1:0]    state;
    logic [1:0]    state_d;
    logic          held_q;
    logic          held_d;
    logic          press_q;
    logic          rise;
    logic          fall;
    logic          rpt_pulse;

    // Next debounced level: flips once the input has disagreed for DEBOUNCE_CYCLES edges.
    always_comb begin
      held_d = held_q;
      if ((sync_b[i] != held_q) && (db_cnt == DB_LAST)) begin
        held_d = ~held_q;
      end
    end

    assign rise = held_d & ~held_q;
    assign fall = ~held_d & held_q;

    // Stability counter and debounced level; any agreement restarts the count.
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        db_cnt <= '0;
        held_q <= 1'b0;
      end else if (sync_b[i] == held_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        held_q <= ~held_q;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    // Repeat FSM next state; a falling debounced level overrides everything, killing any pulse.
    always_comb begin
      state_d   = state;
      rpt_cnt_d = rpt_cnt;
      rpt_pulse = 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state_d   = ST_DELAY;
            rpt_cnt_d = '0;
          end
        end
        ST_DELAY: begin
          if (!REPEAT_EN) begin
            rpt_cnt_d = '0;
          end else if (rpt_cnt == RD_LAST) begin
            rpt_pulse = 1'b1;
            state_d   = ST_REPEAT;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!REPEAT_EN) begin
            state_d   = ST_DELAY;
            rpt_cnt_d = '0;
          end else if (rpt_cnt == RR_LAST) begin
            rpt_pulse = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt + 1'b1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          rpt_cnt_d = '0;
        end
      endcase
      if (fall) begin
        state_d   = ST_IDLE;
        rpt_cnt_d = '0;
        rpt_pulse = 1'b0;
      end
    end

    // Repeat FSM registers and the registered press pulse, aligned with the HELD rise.
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        state   <= ST_IDLE;
        rpt_cnt <= '0;
        press_q <= 1'b0;
      end else begin
        state   <= state_d;
        rpt_cnt <= rpt_cnt_d;
        press_q <= rise | rpt_pulse;
      end
    end

    assign HELD[i]  = held_q;
    assign PRESS[i] = press_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce
module tb_key_debounce;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] KEY;
  logic       REPEAT_EN;
  logic [3:0] PRESS;
  logic [3:0] HELD;

  int tests = 0;
  int fails = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .KEY      (KEY),
    .REPEAT_EN(REPEAT_EN),
    .PRESS    (PRESS),
    .HELD     (HELD)
  );

  always #5 CLK = ~CLK;

  // Reference model: pin level reaches the debouncer two edges late; a level is accepted
  // after DB consecutive disagreeing edges; repeat pulses are scheduled by absolute edge number.
  typedef struct packed {
    logic p1;
    logic p2;
    logic held;
    logic press;
    int   run;
    int   nxt;
  } key_t;

  key_t mk [4];
  int   m_n;

  function automatic key_t step(key_t k, logic key_n, logic en, int n);
    key_t o   = k;
    logic old = k.held;
    logic s   = k.p2;
    o.p2    = k.p1;
    o.p1    = ~key_n;
    o.press = 1'b0;
    if (s != old) begin
      o.run = k.run + 1;
      if (o.run == DB) begin
        o.held = ~old;
        o.run  = 0;
      end
    end else begin
      o.run = 0;
    end
    if (o.held && !old) begin
      o.press = 1'b1;
      o.nxt   = n + RD;
    end else if (o.held) begin
      if (!en) begin
        o.nxt = n + RD;
      end else if (n == k.nxt) begin
        o.press = 1'b1;
        o.nxt   = n + RR;
      end
    end
    return o;
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) mk[i] = '0;
    m_n = 0;
    forever begin
      @(posedge CLK or negedge RESET_N);
      if (!RESET_N) begin
        for (int i = 0; i < 4; i++) mk[i] = '0;
        m_n = 0;
      end else begin
        m_n = m_n + 1;
        for (int i = 0; i < 4; i++) mk[i] = step(mk[i], KEY[i], REPEAT_EN, m_n);
      end
    end
  end

  task automatic test_reset();
    logic [3:0] ep;
    logic [3:0] eh;
    RESET_N = 1'b0; KEY = 4'b0000; REPEAT_EN = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      tests++;
      if (PRESS !== 4'b0000 || HELD !== 4'b0000) begin
        fails++;
        $display("FAIL reset_hold k=%0d PRESS=%b HELD=%b required 0000/0000", k, PRESS, HELD);
      end
    end
    RESET_N = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge CLK);
      ep = (k == DB + 2) ? 4'b1111 : 4'b0000;
      eh = (k >= DB + 2 && k < 10 + DB + 2) ? 4'b1111 : 4'b0000;
      tests++;
      if (PRESS !== ep || HELD !== eh) begin
        fails++;
        $display("FAIL held_through_reset k=%0d PRESS=%b exp %b HELD=%b exp %b", k, PRESS, ep, HELD, eh);
      end
      if (k == 10) KEY = 4'b1111;
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] ep;
    logic [3:0] eh;
    @(negedge CLK); REPEAT_EN = 1'b0; KEY = 4'b1110;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLK);
      ep = (k == 6) ? 4'b0001 : 4'b0000;
      eh = (k >= 6 && k < 26) ? 4'b0001 : 4'b0000;
      tests++;
      if (PRESS !== ep || HELD !== eh) begin
        fails++;
        $display("FAIL clean_press k=%0d PRESS=%b exp %b HELD=%b exp %b", k, PRESS, ep, HELD, eh);
      end
      if (k == 20) KEY = 4'b1111;
    end
  endtask

  task automatic test_bounce();
    logic [3:0] ep;
    logic [3:0] eh;
    @(negedge CLK); REPEAT_EN = 1'b0;
    for (int c = 0; c < 20; c++) begin
      KEY[1] = ((c / 2) % 2 == 1);
      @(negedge CLK);
      tests++;
      if (PRESS !== 4'b0000 || HELD !== 4'b0000) begin
        fails++;
        $display("FAIL bounce c=%0d PRESS=%b HELD=%b required 0000/0000", c, PRESS, HELD);
      end
    end
    KEY[1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      ep = (k == 6) ? 4'b0010 : 4'b0000;
      eh = (k >= 6 && k < 16) ? 4'b0010 : 4'b0000;
      tests++;
      if (PRESS !== ep || HELD !== eh) begin
        fails++;
        $display("FAIL bounce_settle k=%0d PRESS=%b exp %b HELD=%b exp %b", k, PRESS, ep, HELD, eh);
      end
      if (k == 10) KEY = 4'b1111;
    end
  endtask

  task automatic test_repeat();
    logic [3:0] ep;
    logic [3:0] eh;
    @(negedge CLK); REPEAT_EN = 1'b1; KEY = 4'b1011;
    for (int k = 1; k <= 34; k++) begin
      @(negedge CLK);
      ep = (k == 6 || k == 16 || k == 19 || k == 22 || k == 25) ? 4'b0100 : 4'b0000;
      eh = (k >= 6 && k < 28) ? 4'b0100 : 4'b0000;
      tests++;
      if (PRESS !== ep || HELD !== eh) begin
        fails++;
        $display("FAIL repeat k=%0d PRESS=%b exp %b HELD=%b exp %b", k, PRESS, ep, HELD, eh);
      end
      if (k == 22) KEY = 4'b1111;
    end
    REPEAT_EN = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [3:0] ep;
    logic [3:0] eh;
    @(negedge CLK); REPEAT_EN = 1'b0; KEY = 4'b0110;
    for (int k = 1; k <= 24; k++) begin
      @(negedge CLK);
      ep    = (k == 6) ? 4'b1001 : 4'b0000;
      eh    = 4'b0000;
      eh[0] = (k >= 6 && k < 20);
      eh[3] = (k >= 6 && k < 11);
      tests++;
      if (PRESS !== ep || HELD !== eh) begin
        fails++;
        $display("FAIL simultaneous k=%0d PRESS=%b exp %b HELD=%b exp %b", k, PRESS, ep, HELD, eh);
      end
      if (k == 5)  KEY[3] = 1'b1;
      if (k == 14) KEY[0] = 1'b1;
    end
  endtask

  task automatic test_reset_repeat();
    logic [3:0] ep;
    logic [3:0] eh;
    @(negedge CLK); REPEAT_EN = 1'b1; KEY = 4'b1101;
    for (int k = 1; k <= 18; k++) begin
      @(negedge CLK);
      ep = (k == 6 || k == 16) ? 4'b0010 : 4'b0000;
      eh = (k >= 6) ? 4'b0010 : 4'b0000;
      tests++;
      if (PRESS !== ep || HELD !== eh) begin
        fails++;
        $display("FAIL pre_reset k=%0d PRESS=%b exp %b HELD=%b exp %b", k, PRESS, ep, HELD, eh);
      end
    end
    #2 RESET_N = 1'b0;
    #1;
    tests++;
    if (PRESS !== 4'b0000 || HELD !== 4'b0000) begin
      fails++;
      $display("FAIL reset_async PRESS=%b HELD=%b required 0000/0000", PRESS, HELD);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      tests++;
      if (PRESS !== 4'b0000 || HELD !== 4'b0000) begin
        fails++;
        $display("FAIL reset_during k=%0d PRESS=%b HELD=%b required 0000/0000", k, PRESS, HELD);
      end
    end
    RESET_N = 1'b1;
    for (int j = 1; j <= 26; j++) begin
      @(negedge CLK);
      ep = (j == 6 || j == 16 || j == 19) ? 4'b0010 : 4'b0000;
      eh = (j >= 6 && j < 22) ? 4'b0010 : 4'b0000;
      tests++;
      if (PRESS !== ep || HELD !== eh) begin
        fails++;
        $display("FAIL post_reset j=%0d PRESS=%b exp %b HELD=%b exp %b", j, PRESS, ep, HELD, eh);
      end
      if (j == 16) KEY = 4'b1111;
    end
    REPEAT_EN = 1'b0;
  endtask

  task automatic test_repeat_en();
    logic [3:0] ep;
    logic [3:0] eh;
    @(negedge CLK); REPEAT_EN = 1'b1; KEY = 4'b0111;
    for (int k = 1; k <= 50; k++) begin
      @(negedge CLK);
      ep = (k == 6 || k == 16 || k == 19 || k == 35 || k == 38 || k == 41) ? 4'b1000 : 4'b0000;
      eh = (k >= 6 && k < 44) ? 4'b1000 : 4'b0000;
      tests++;
      if (PRESS !== ep || HELD !== eh) begin
        fails++;
        $display("FAIL repeat_en k=%0d PRESS=%b exp %b HELD=%b exp %b", k, PRESS, ep, HELD, eh);
      end
      if (k == 20) REPEAT_EN = 1'b0;
      if (k == 25) REPEAT_EN = 1'b1;
      if (k == 38) KEY = 4'b1111;
    end
    REPEAT_EN = 1'b0;
  endtask

  task automatic test_random();
    int         hold [4];
    int         rst_left;
    logic [3:0] ep;
    logic [3:0] eh;
    rst_left = 0;
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int c = 0; c < 900; c++) begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
        ep[i] = mk[i].press;
        eh[i] = mk[i].held;
      end
      tests++;
      if (PRESS !== ep || HELD !== eh) begin
        fails++;
        $display("FAIL random c=%0d PRESS=%b exp %b HELD=%b exp %b", c, PRESS, ep, HELD, eh);
      end
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) RESET_N = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        #2 RESET_N = 1'b0;
        rst_left = $urandom_range(1, 3);
      end
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          KEY[i]  = 1'($urandom_range(0, 1));
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 6);
        end else begin
          hold[i]--;
        end
      end
      if ($urandom_range(0, 24) == 0) REPEAT_EN = ~REPEAT_EN;
    end
    RESET_N = 1'b1;
    KEY     = 4'b1111;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_simultaneous();
    test_reset_repeat();
    test_repeat_en();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
